// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined extended-Hamming (SECDED) decoder with a valid/ready stream and saturating error counters.
// Stage 1 computes syndrome/parity and captures raw data; stage 2 corrects and classifies.
module hamming_secded_dec_pipe #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned R = (DATA_W <= 1)  ? 2 :
                              (DATA_W <= 4)  ? 3 :
                              (DATA_W <= 11) ? 4 :
                              (DATA_W <= 26) ? 5 :
                              (DATA_W <= 57) ? 6 : 7,
  localparam int unsigned CW_W  = DATA_W + R + 1,
  localparam int unsigned SYN_W = R
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SYN_W-1:0]  out_syn,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 upward.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx && pos == 0) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_dat;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_en;

  logic              s1_ready;
  logic              s2_ready;
  logic [SYN_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] fix_c;
  logic              in_range_c;
  logic              single_c;
  logic              double_c;
  logic              flip_c;
  logic              out_fire;

  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign out_fire = out_valid && out_ready;

  // Syndrome is the XOR of the indices of all set bits at positions >= 1.
  always_comb begin
    syn_c = '0;
    for (int unsigned p = 1; p < CW_W; p++) begin
      if (in_cw[p]) syn_c = syn_c ^ SYN_W'(p);
    end
    par_c = ^in_cw;
  end

  assign in_range_c = 32'(s1_syn) < CW_W;
  assign single_c   = s1_par && in_range_c;
  assign double_c   = (!s1_par && (s1_syn != '0)) || (s1_par && !in_range_c);
  assign flip_c     = s1_en && single_c;

  for (genvar i = 0; i < DATA_W; i++) begin : g_dat
    localparam int unsigned POS = data_pos(i);
    assign raw_c[i] = in_cw[POS];
    assign fix_c[i] = s1_dat[i] ^ (flip_c && (s1_syn == SYN_W'(POS)));
  end

  // Stage 1: syndrome, overall parity and raw data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dat   <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_en    <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dat <= raw_c;
        s1_syn <= syn_c;
        s1_par <= par_c;
        s1_en  <= corr_en;
      end
    end
  end

  // Stage 2: corrected data and error classification; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_syn    <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data   <= fix_c;
        out_syn    <= s1_syn;
        out_corr   <= single_c;
        out_uncorr <= double_c;
      end
    end
  end

  // Saturating statistics on delivered words; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_fire) begin
      if (out_corr && cnt_corr != CNT_MAX)     cnt_corr   <= cnt_corr + CNT_W'(1);
      if (out_uncorr && cnt_uncorr != CNT_MAX) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

endmodule
